// File: rtl/modn_counter.sv
// modn_counter: free-running modulo-M up-counter with an N-bit registered output.
// The count steps 0,1,..,M-1,0,... once per rising clk edge while rst is high.
// An asynchronous low-going rst clears the count at once, with no clock needed.
// Any state at or above M-1 returns to 0 on the next edge. That covers the normal
// wrap, and it also recovers an upset state when M < 2**N.
module modn_counter #(
  parameter int unsigned     N = 2,
  parameter longint unsigned M = 3
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] Q
);

  // Reject out-of-range parameters when the design is elaborated.
  // Without this check, M-1 would be truncated silently to N bits.
  if (N < 1 || N > 32) begin : g_bad_n
    $error("modn_counter: N=%0d outside legal range 1..32", N);
  end
  if (M < 2 || M > (64'd1 << N)) begin : g_bad_m
    $error("modn_counter: M=%0d outside legal range 2..2**N (N=%0d)", M, N);
  end

  // The terminal count is M-1, computed at full width before it is narrowed to N bits.
  // The range check above guarantees that this value fits in N bits.
  localparam logic [63:0]  MAX64 = 64'(M) - 64'd1;
  localparam logic [N-1:0] MAX   = MAX64[N-1:0];
  localparam logic [N-1:0] ONE   = N'(1);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Next count: wrap at M-1. Any value above M-1 (reachable only through an upset) also goes to 0.
  always_comb begin
    q_d = q_q + ONE;
    if (q_q >= MAX) q_d = '0;
  end

  // State register: clears asynchronously while rst is low and advances on each rising edge otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: tb/tb_modn_counter.sv
// tb_modn_counter: directed checks for modn_counter across several N/M pairs.
// Expected values are hand-computed tables and constants.
module tb_modn_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] q3;   // N=2, M=3 (default shape)
  logic [1:0] q4;   // N=2, M=4 (wrap equals natural overflow)
  logic       q2;   // N=1, M=2 (smallest legal)
  logic [2:0] q8;   // N=3, M=8

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  modn_counter #(.N(2), .M(3)) dut3 (.clk(clk), .rst(rst), .Q(q3));
  modn_counter #(.N(2), .M(4)) dut4 (.clk(clk), .rst(rst), .Q(q4));
  modn_counter #(.N(1), .M(2)) dut2 (.clk(clk), .rst(rst), .Q(q2));
  modn_counter #(.N(3), .M(8)) dut8 (.clk(clk), .rst(rst), .Q(q8));

  task automatic test_reset();
    // rst is low from time 0, so every output must already read 0
    #1;
    chk_cnt++;
    if ({q3, q4, q2, q8} !== 8'd0) $display("FAIL reset_initial: got q3=%0d q4=%0d q2=%0d q8=%0d, want all 0", q3, q4, q2, q8);
    else pass_cnt++;
    // hold reset through one rising edge
    @(posedge clk); #1;
    chk_cnt++;
    if ({q3, q4, q2, q8} !== 8'd0) $display("FAIL reset_held: got q3=%0d q4=%0d q2=%0d q8=%0d, want all 0", q3, q4, q2, q8);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1; #1;
    chk_cnt++;
    if (q3 !== 2'd0) $display("FAIL reset_release: got %0d want 0", q3);
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    logic [31:0] e3[8] = '{1, 2, 0, 1, 2, 0, 1, 2};
    logic [31:0] e4[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic [31:0] e2[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    logic [31:0] e8[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if (32'(q3) !== e3[k]) $display("FAIL seq_m3[%0d]: got %0d want %0d", k, q3, e3[k]);
      else pass_cnt++;
      chk_cnt++;
      if (32'(q4) !== e4[k]) $display("FAIL seq_m4[%0d]: got %0d want %0d", k, q4, e4[k]);
      else pass_cnt++;
      chk_cnt++;
      if (32'(q2) !== e2[k]) $display("FAIL seq_m2[%0d]: got %0d want %0d", k, q2, e2[k]);
      else pass_cnt++;
      chk_cnt++;
      if (32'(q8) !== e8[k]) $display("FAIL seq_m8[%0d]: got %0d want %0d", k, q8, e8[k]);
      else pass_cnt++;
    end
  endtask

  // advance dut3 until it shows 2, with a bounded number of edges
  task automatic run_to_two(input string tag);
    int n = 0;
    while (q3 !== 2'd2 && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    chk_cnt++;
    if (q3 !== 2'd2) $display("FAIL %s_reach2: got %0d want 2 within 6 edges", tag, q3);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    run_to_two("async");
    @(negedge clk); rst = 1'b0; #1;
    chk_cnt++;
    if ({q3, q4, q2, q8} !== 8'd0) $display("FAIL async_clear: got q3=%0d q4=%0d q2=%0d q8=%0d, want all 0", q3, q4, q2, q8);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (q3 !== 2'd0) $display("FAIL async_hold: got %0d want 0", q3);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1; #1;
    chk_cnt++;
    if (q3 !== 2'd0) $display("FAIL async_release: got %0d want 0", q3);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (q3 !== 2'd1 || q4 !== 2'd1) $display("FAIL async_restart: got q3=%0d q4=%0d want 1 1", q3, q4);
    else pass_cnt++;
  endtask

  task automatic test_short_pulse();
    // Pulse lasting one full clock: exactly one rising edge is suppressed.
    run_to_two("pulse");
    @(negedge clk); rst = 1'b0; #1;
    chk_cnt++;
    if (q3 !== 2'd0) $display("FAIL pulse_clear: got %0d want 0", q3);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1; #1;
    chk_cnt++;
    if (q3 !== 2'd0) $display("FAIL pulse_release: got %0d want 0", q3);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (q3 !== 2'd1) $display("FAIL pulse_next: got %0d want 1", q3);
    else pass_cnt++;
    // Glitch pulse far shorter than a clock, with no edge inside it.
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; #2; rst = 1'b1; #1;
    chk_cnt++;
    if (q3 !== 2'd0) $display("FAIL glitch_clear: got %0d want 0", q3);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (q3 !== 2'd1) $display("FAIL glitch_next: got %0d want 1", q3);
    else pass_cnt++;
  endtask

  task automatic test_illegal_state();
    logic [31:0] e[4] = '{0, 1, 2, 0};
    @(negedge clk);
    force dut3.q_q = 2'd3;
    #1 release dut3.q_q;
    #1;
    chk_cnt++;
    if (q3 !== 2'd3) $display("FAIL illegal_forced: got %0d want 3", q3);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if (32'(q3) !== e[k]) $display("FAIL illegal_recover[%0d]: got %0d want %0d", k, q3, e[k]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_async_reset();
    test_short_pulse();
    test_illegal_state();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
